// File: rtl/dmem_arbiter.sv
// Two-way arbiter and sequencer for the single-ported data RAM behind the MEM stage (pipe vs DMA).
// Latency: grant on the first edge, done/ack registered on the edge that samples ram_ready, one DONE bubble.
// Backpressure: stall holds the pipe until pipe_done; DMA holds dma_req until dma_ack, and loses to the pipe at most MAX_WAIT times.
module dmem_arbiter #(
    parameter int ADDR_W   = 5,
    parameter int DATA_W   = 32,
    parameter int MAX_WAIT = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              pipe_rd,
    input  logic              pipe_wr,
    input  logic [31:0]       pipe_adr,
    input  logic [DATA_W-1:0] pipe_wdata,
    output logic [DATA_W-1:0] pipe_rdata,
    output logic              pipe_done,
    output logic              stall,
    input  logic              dma_req,
    input  logic              dma_we,
    input  logic [ADDR_W-1:0] dma_adr,
    input  logic [DATA_W-1:0] dma_wdata,
    output logic [DATA_W-1:0] dma_rdata,
    output logic              dma_ack,
    output logic              ram_en,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_adr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata,
    input  logic              ram_ready,
    output logic              adr_err
);

    typedef enum logic [1:0] {IDLE, PIPE, DMA, DONE} state_t;

    localparam logic [3:0] WAIT_MAX = 4'(MAX_WAIT);

    state_t             state, state_nxt;
    logic               ram_en_nxt, ram_we_nxt, pipe_done_nxt, dma_ack_nxt, adr_err_nxt;
    logic [ADDR_W-1:0]  ram_adr_nxt;
    logic [DATA_W-1:0]  ram_wdata_nxt, pipe_rdata_nxt, dma_rdata_nxt;
    logic [3:0]         wait_cnt, wait_cnt_nxt;
    logic               pipe_req, dma_win, adr_hi;

    assign pipe_req = pipe_rd | pipe_wr;
    assign stall    = pipe_req & ~pipe_done;
    // DMA wins when alone, or when it has already lost MAX_WAIT times in a row.
    assign dma_win  = dma_req & (~pipe_req | (wait_cnt == WAIT_MAX));
    assign adr_hi   = |pipe_adr[31:ADDR_W];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            ram_en     <= 1'b0;
            ram_we     <= 1'b0;
            ram_adr    <= '0;
            ram_wdata  <= '0;
            pipe_done  <= 1'b0;
            dma_ack    <= 1'b0;
            pipe_rdata <= '0;
            dma_rdata  <= '0;
            adr_err    <= 1'b0;
            wait_cnt   <= '0;
        end else begin
            state      <= state_nxt;
            ram_en     <= ram_en_nxt;
            ram_we     <= ram_we_nxt;
            ram_adr    <= ram_adr_nxt;
            ram_wdata  <= ram_wdata_nxt;
            pipe_done  <= pipe_done_nxt;
            dma_ack    <= dma_ack_nxt;
            pipe_rdata <= pipe_rdata_nxt;
            dma_rdata  <= dma_rdata_nxt;
            adr_err    <= adr_err_nxt;
            wait_cnt   <= wait_cnt_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        ram_en_nxt     = ram_en;
        ram_we_nxt     = ram_we;
        ram_adr_nxt    = ram_adr;
        ram_wdata_nxt  = ram_wdata;
        pipe_done_nxt  = 1'b0;
        dma_ack_nxt    = 1'b0;
        pipe_rdata_nxt = pipe_rdata;
        dma_rdata_nxt  = dma_rdata;
        adr_err_nxt    = adr_err;
        wait_cnt_nxt   = wait_cnt;
        case (state)
            IDLE: begin
                if (dma_win) begin
                    state_nxt     = DMA;
                    ram_en_nxt    = 1'b1;
                    ram_we_nxt    = dma_we;
                    ram_adr_nxt   = dma_adr;
                    ram_wdata_nxt = dma_wdata;
                    wait_cnt_nxt  = '0;
                end else if (pipe_req) begin
                    state_nxt     = PIPE;
                    ram_en_nxt    = 1'b1;
                    ram_we_nxt    = pipe_wr;
                    ram_adr_nxt   = pipe_adr[ADDR_W-1:0];
                    ram_wdata_nxt = pipe_wdata;
                    if (adr_hi)
                        adr_err_nxt = 1'b1;
                    if (dma_req && (wait_cnt != WAIT_MAX))
                        wait_cnt_nxt = wait_cnt + 4'd1;
                end
            end
            PIPE: begin
                if (ram_ready) begin
                    state_nxt     = DONE;
                    ram_en_nxt    = 1'b0;
                    pipe_done_nxt = 1'b1;
                    if (!ram_we)
                        pipe_rdata_nxt = ram_rdata;
                end
            end
            DMA: begin
                if (ram_ready) begin
                    state_nxt   = DONE;
                    ram_en_nxt  = 1'b0;
                    dma_ack_nxt = 1'b1;
                    if (!ram_we)
                        dma_rdata_nxt = ram_rdata;
                end
            end
            DONE: begin
                // Bubble so a completed requester can drop its request before re-arbitration.
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: pipe read/write, contention fairness, address errors, async reset.
module tb_dmem_arbiter;

    localparam int ADDR_W = 5;
    localparam int DATA_W = 32;

    logic              clk;
    logic              rst_n;
    logic              pipe_rd, pipe_wr;
    logic [31:0]       pipe_adr;
    logic [DATA_W-1:0] pipe_wdata, pipe_rdata;
    logic              pipe_done, stall;
    logic              dma_req, dma_we, dma_ack;
    logic [ADDR_W-1:0] dma_adr;
    logic [DATA_W-1:0] dma_wdata, dma_rdata;
    logic              ram_en, ram_we, ram_ready, adr_err;
    logic [ADDR_W-1:0] ram_adr;
    logic [DATA_W-1:0] ram_wdata, ram_rdata;

    int checks = 0;
    int errors = 0;

    dmem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_WAIT(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .pipe_rd    (pipe_rd),
        .pipe_wr    (pipe_wr),
        .pipe_adr   (pipe_adr),
        .pipe_wdata (pipe_wdata),
        .pipe_rdata (pipe_rdata),
        .pipe_done  (pipe_done),
        .stall      (stall),
        .dma_req    (dma_req),
        .dma_we     (dma_we),
        .dma_adr    (dma_adr),
        .dma_wdata  (dma_wdata),
        .dma_rdata  (dma_rdata),
        .dma_ack    (dma_ack),
        .ram_en     (ram_en),
        .ram_we     (ram_we),
        .ram_adr    (ram_adr),
        .ram_wdata  (ram_wdata),
        .ram_rdata  (ram_rdata),
        .ram_ready  (ram_ready),
        .adr_err    (adr_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic is_dma;
        rst_n = 1'b0;
        pipe_rd = 0; pipe_wr = 0; pipe_adr = '0; pipe_wdata = '0;
        dma_req = 0; dma_we = 0; dma_adr = '0; dma_wdata = '0;
        ram_ready = 0; ram_rdata = '0;
        #2;
        check("rst_ram_en", ram_en, 0);
        check("rst_pipe_done", pipe_done, 0);
        check("rst_adr_err", adr_err, 0);
        check("rst_stall", stall, 0);
        check("rst_pipe_rdata", pipe_rdata, 0);
        step(); step();
        rst_n = 1'b1;
        step();

        // Pipe read, ram_ready one cycle after ram_en.
        pipe_rd = 1; pipe_adr = 32'd7; ram_rdata = 32'hDEADBEEF;
        #1 check("rd_stall_req", stall, 1);
        step();
        check("rd_ram_en", ram_en, 1);
        check("rd_ram_adr", ram_adr, 7);
        check("rd_ram_we", ram_we, 0);
        ram_ready = 1;
        step();
        check("rd_done", pipe_done, 1);
        check("rd_rdata", pipe_rdata, 32'hDEADBEEF);
        check("rd_stall_done", stall, 0);
        check("rd_ram_en_drop", ram_en, 0);
        pipe_rd = 0; ram_ready = 0;
        step();
        check("rd_done_once", pipe_done, 0);

        // Pipe write, ram_ready after 4 cycles.
        pipe_wr = 1; pipe_adr = 32'd3; pipe_wdata = 32'h12345678;
        step();
        for (int i = 0; i < 4; i++) begin
            check("wr_ram_en", ram_en, 1);
            check("wr_ram_adr", ram_adr, 3);
            check("wr_ram_wdata", ram_wdata, 32'h12345678);
            check("wr_ram_we", ram_we, 1);
            check("wr_stall", stall, 1);
            check("wr_no_done", pipe_done, 0);
            if (i == 3) ram_ready = 1;
            step();
        end
        check("wr_done", pipe_done, 1);
        check("wr_ram_en_drop", ram_en, 0);
        check("wr_rdata_kept", pipe_rdata, 32'hDEADBEEF);
        pipe_wr = 0; ram_ready = 0;
        step();
        check("wr_done_once", pipe_done, 0);

        // Contention: pipe x4 then dma x1, repeating.
        pipe_rd = 1; pipe_adr = 32'd2; dma_req = 1; dma_we = 0; dma_adr = 5'd10; ram_ready = 1;
        for (int k = 0; k < 10; k++) begin
            is_dma = (k % 5 == 4);
            step();
            check("arb_ram_adr", ram_adr, is_dma ? 32'd10 : 32'd2);
            ram_rdata = 32'h1000 + k;
            step();
            check("arb_pipe_done", pipe_done, !is_dma);
            check("arb_dma_ack", dma_ack, is_dma);
            if (is_dma) check("arb_dma_rdata", dma_rdata, 32'h1000 + k);
            else        check("arb_pipe_rdata", pipe_rdata, 32'h1000 + k);
            step();
        end
        pipe_rd = 0; dma_req = 0; ram_ready = 0;
        step();

        // DMA write alone.
        dma_req = 1; dma_we = 1; dma_adr = 5'd20; dma_wdata = 32'h0000BEEF; ram_ready = 1;
        step();
        check("dwr_ram_we", ram_we, 1);
        check("dwr_ram_adr", ram_adr, 20);
        check("dwr_ram_wdata", ram_wdata, 32'h0000BEEF);
        step();
        check("dwr_ack", dma_ack, 1);
        check("dwr_rdata_kept", dma_rdata, 32'h1009);
        dma_req = 0; ram_ready = 0;
        step();

        // Simultaneous rd and wr: treated as write.
        pipe_rd = 1; pipe_wr = 1; pipe_adr = 32'd9; pipe_wdata = 32'hCAFEF00D;
        ram_rdata = 32'h0BADBAD0; ram_ready = 1;
        step();
        check("rw_ram_we", ram_we, 1);
        check("rw_ram_adr", ram_adr, 9);
        check("rw_ram_wdata", ram_wdata, 32'hCAFEF00D);
        step();
        check("rw_done", pipe_done, 1);
        check("rw_rdata_kept", pipe_rdata, 32'h1008);
        pipe_rd = 0; pipe_wr = 0;
        step();

        // Out-of-range address: truncated, sticky error.
        check("oor_err_before", adr_err, 0);
        pipe_rd = 1; pipe_adr = 32'h25; ram_rdata = 32'h55;
        step();
        check("oor_ram_adr", ram_adr, 5);
        check("oor_adr_err", adr_err, 1);
        step();
        check("oor_done", pipe_done, 1);
        pipe_rd = 0;
        step();
        pipe_rd = 1; pipe_adr = 32'd4;
        step();
        check("oor_legal_adr", ram_adr, 4);
        check("oor_sticky1", adr_err, 1);
        step();
        pipe_rd = 0;
        step();
        check("oor_sticky2", adr_err, 1);

        // Reset mid-access.
        pipe_rd = 1; pipe_adr = 32'd6; ram_ready = 0; ram_rdata = 32'h77;
        step();
        check("mid_ram_en", ram_en, 1);
        #2 rst_n = 1'b0;
        #1;
        check("arst_ram_en", ram_en, 0);
        check("arst_ram_we", ram_we, 0);
        check("arst_ram_adr", ram_adr, 0);
        check("arst_ram_wdata", ram_wdata, 0);
        check("arst_pipe_rdata", pipe_rdata, 0);
        check("arst_dma_rdata", dma_rdata, 0);
        check("arst_adr_err", adr_err, 0);
        check("arst_stall", stall, 1);
        pipe_rd = 0;
        #1 check("arst_stall_idle", stall, 0);
        step();
        rst_n = 1'b1;
        step();
        pipe_rd = 1; pipe_adr = 32'd11; ram_rdata = 32'h600D; ram_ready = 1;
        step();
        check("post_ram_en", ram_en, 1);
        check("post_ram_adr", ram_adr, 11);
        step();
        check("post_done", pipe_done, 1);
        check("post_rdata", pipe_rdata, 32'h600D);
        pipe_rd = 0; ram_ready = 0;
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
